// File: rtl/bpred_pkg.sv
// bpred_pkg: shared defaults and sizing helpers for the branch predictor
package bpred_pkg;
  localparam int ENTRIES_DEF = 16;
  localparam int CTR_W_DEF = 2;
  localparam int WORD_W_DEF = 32;
  localparam int STAT_W_DEF = 16;
  function automatic int ctr_rst_val(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int ctr_alloc_val(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic int idx_w_of(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int tag_w_of(input int word_w, input int entries);
    return word_w - $clog2(entries) - 2;
  endfunction
endpackage

// File: rtl/bpred_sat_ctr.sv
// bpred_sat_ctr: saturating up/down counter with synchronous clear (to CLR_VAL) and load
// ports: clk; clr clear; ld/ld_val load; inc/dec step, held at all-ones / zero; q count
module bpred_sat_ctr #(
  parameter int W = 2,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? CLR_VAL :
            ld ? ld_val :
            (inc && cnt_q != {W{1'b1}}) ? cnt_q + 1'b1 :
            (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating confidence and stats
// ports: CLK/RST; rd_* fetch lookup -> pred_*; upd_* EX resolution -> mispredict;
//        flush_all invalidates table; stat_lookups/stat_mispredicts saturating totals
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int CTR_W = CTR_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rd_en,
  input  logic [WORD_W-1:0] rd_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [WORD_W-1:0] upd_pred_target,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = idx_w_of(ENTRIES);
  localparam int TAG_W = tag_w_of(WORD_W, ENTRIES);
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_rst_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_alloc_val(CTR_W));
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [TAG_W-1:0] tag_d [ENTRIES];
  logic [WORD_W-1:0] tgt_q [ENTRIES];
  logic [WORD_W-1:0] tgt_d [ENTRIES];
  logic [CTR_W-1:0] ctr [ENTRIES];
  logic [ENTRIES-1:0] sel;
  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic upd_hit, do_upd;
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};
  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[WORD_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[WORD_W-1:IDX_W+2];
  assign pred_hit = valid_q[rd_idx] && tag_q[rd_idx] == rd_tag;
  assign pred_taken = pred_hit && ctr[rd_idx][CTR_W-1];
  assign pred_target = pred_taken ? tgt_q[rd_idx] : rd_pc + WORD_W'(4);
  assign mispredict = upd_en & ((upd_taken != upd_pred_taken) |
                      (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
  assign upd_hit = valid_q[upd_idx] && tag_q[upd_idx] == upd_tag;
  assign do_upd = upd_en & ~flush_all;
  // a taken resolution either refreshes a hit or allocates over the resident entry;
  // both write the same tag/target, so one path covers them
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    sel = '0;
    if (do_upd) sel[upd_idx] = 1'b1;
    if (flush_all) valid_d = '0;
    else if (do_upd && upd_taken) begin
      valid_d[upd_idx] = 1'b1;
      tag_d[upd_idx] = upd_tag;
      tgt_d[upd_idx] = upd_target;
    end
  end
  always_ff @(posedge CLK) begin
    valid_q <= RST ? '0 : valid_d;
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    bpred_sat_ctr #(.W(CTR_W), .CLR_VAL(CTR_RST)) u_ctr (
      .clk(CLK), .clr(RST),
      .ld(sel[g] & ~upd_hit & upd_taken), .ld_val(CTR_ALLOC),
      .inc(sel[g] & upd_hit & upd_taken), .dec(sel[g] & upd_hit & ~upd_taken),
      .q(ctr[g])
    );
  end
  bpred_sat_ctr #(.W(STAT_W), .CLR_VAL('0)) u_stat_lookups (
    .clk(CLK), .clr(RST), .ld(1'b0), .ld_val('0),
    .inc(rd_en), .dec(1'b0), .q(stat_lookups)
  );
  bpred_sat_ctr #(.W(STAT_W), .CLR_VAL('0)) u_stat_mispredicts (
    .clk(CLK), .clr(RST), .ld(1'b0), .ld_val('0),
    .inc(mispredict), .dec(1'b0), .q(stat_mispredicts)
  );
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
  logic CLK, RST, rd_en, pred_hit, pred_taken, upd_en, upd_taken, upd_pred_taken, flush_all, mispredict;
  logic [31:0] rd_pc, pred_target, upd_pc, upd_target, upd_pred_target;
  logic [3:0] stat_lookups, stat_mispredicts;
  int checks = 0, errors = 0;
  branch_predictor #(.ENTRIES(16), .CTR_W(2), .WORD_W(32), .STAT_W(4)) dut (
    .CLK(CLK), .RST(RST), .rd_en(rd_en), .rd_pc(rd_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush_all(flush_all), .mispredict(mispredict),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle;
    rd_en = 1'b0;
    upd_en = 1'b0;
    flush_all = 1'b0;
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt);
    upd_en = 1'b1;
    upd_pc = pc;
    upd_taken = t;
    upd_target = tgt;
    upd_pred_taken = pt;
    upd_pred_target = ptgt;
  endtask
  task automatic look(input logic [31:0] pc);
    rd_pc = pc;
    #1;
  endtask
  task automatic test_reset;
    rd_en = 1'b1;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h44}) begin errors++; $display("FAIL reset_lookup: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b00, 32'h44}); end
    checks++; if (stat_lookups !== 4'd0) begin errors++; $display("FAIL reset_lookups: got %0d want 0", stat_lookups); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
    tick;
    idle;
    checks++; if (stat_lookups !== 4'd1) begin errors++; $display("FAIL lookups_one: got %0d want 1", stat_lookups); end
    checks++; if (stat_mispredicts !== 4'd0) begin errors++; $display("FAIL reset_mispredicts: got %0d want 0", stat_mispredicts); end
  endtask
  task automatic test_mispredict;
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL misp_agree: got %b want 0", mispredict); end
    upd_pred_target = 32'h104;
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL misp_target: got %b want 1", mispredict); end
    upd_taken = 1'b0;
    upd_pred_taken = 1'b0;
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL misp_nt_agree: got %b want 0", mispredict); end
    upd_pred_taken = 1'b1;
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL misp_dir: got %b want 1", mispredict); end
    upd_en = 1'b0;
    #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL misp_noen: got %b want 0", mispredict); end
  endtask
  task automatic test_alloc;
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_misp: got %b want 1", mispredict); end
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h100}) begin errors++; $display("FAIL alloc_lookup: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b11, 32'h100}); end
    checks++; if (stat_mispredicts !== 4'd1) begin errors++; $display("FAIL alloc_stat: got %0d want 1", stat_mispredicts); end
  endtask
  task automatic test_counter;
    for (int i = 0; i < 3; i++) begin
      upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      tick;
      idle;
    end
    upd(32'h40, 1'b0, 32'h300, 1'b0, 32'h44);
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h100}) begin errors++; $display("FAIL ctr_sat_hi: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b11, 32'h100}); end
    upd(32'h40, 1'b0, 32'h300, 1'b0, 32'h44);
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b10, 32'h44}) begin errors++; $display("FAIL ctr_two_nt: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b10, 32'h44}); end
    upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h200}) begin errors++; $display("FAIL ctr_retarget: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b11, 32'h200}); end
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b10, 32'h44}) begin errors++; $display("FAIL ctr_one_nt: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b10, 32'h44}); end
    for (int i = 0; i < 2; i++) begin
      upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      tick;
      idle;
    end
    upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b10, 32'h44}) begin errors++; $display("FAIL ctr_sat_lo: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b10, 32'h44}); end
    upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h200}) begin errors++; $display("FAIL ctr_recover: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b11, 32'h200}); end
    checks++; if (stat_mispredicts !== 4'd1) begin errors++; $display("FAIL ctr_stat: got %0d want 1", stat_mispredicts); end
  endtask
  task automatic test_no_bypass;
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h200}) begin errors++; $display("FAIL bypass_pre: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b11, 32'h200}); end
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b10, 32'h44}) begin errors++; $display("FAIL bypass_post: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b10, 32'h44}); end
  endtask
  task automatic test_alias;
    upd(32'h80, 1'b1, 32'h180, 1'b0, 32'h84);
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h44}) begin errors++; $display("FAIL alias_old: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b00, 32'h44}); end
    look(32'h80);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h180}) begin errors++; $display("FAIL alias_new: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b11, 32'h180}); end
    upd(32'hC0, 1'b0, 32'h999, 1'b0, 32'h0);
    tick;
    idle;
    look(32'hC0);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'hC4}) begin errors++; $display("FAIL miss_nt_alloc: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b00, 32'hC4}); end
    look(32'h80);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h180}) begin errors++; $display("FAIL miss_nt_keep: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b11, 32'h180}); end
    look(32'h44);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h48}) begin errors++; $display("FAIL other_idx: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b00, 32'h48}); end
    look(32'hFFFF_FFFC);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h0}) begin errors++; $display("FAIL pc_wrap: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b00, 32'h0}); end
    checks++; if (stat_mispredicts !== 4'd2) begin errors++; $display("FAIL alias_stat: got %0d want 2", stat_mispredicts); end
  endtask
  task automatic test_flush;
    upd(32'h40, 1'b1, 32'h500, 1'b0, 32'h44);
    flush_all = 1'b1;
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL flush_misp: got %b want 1", mispredict); end
    tick;
    idle;
    look(32'h80);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h84}) begin errors++; $display("FAIL flush_80: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b00, 32'h84}); end
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h44}) begin errors++; $display("FAIL flush_40: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b00, 32'h44}); end
    checks++; if (stat_mispredicts !== 4'd3) begin errors++; $display("FAIL flush_stat: got %0d want 3", stat_mispredicts); end
    upd(32'h40, 1'b1, 32'h600, 1'b1, 32'h600);
    tick;
    idle;
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h600}) begin errors++; $display("FAIL flush_realloc: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b11, 32'h600}); end
  endtask
  task automatic test_stat_sat;
    upd(32'h40, 1'b1, 32'h700, 1'b0, 32'h0);
    rd_en = 1'b1;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    idle;
    checks++; if ({stat_lookups, stat_mispredicts} !== 8'h00) begin errors++; $display("FAIL rst_stats: got %h want 00", {stat_lookups, stat_mispredicts}); end
    look(32'h40);
    checks++; if ({pred_hit, pred_taken, pred_target} !== {2'b00, 32'h44}) begin errors++; $display("FAIL rst_discard: got %h want %h", {pred_hit, pred_taken, pred_target}, {2'b00, 32'h44}); end
    rd_en = 1'b1;
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (i == 14) begin
        checks++; if ({stat_lookups, stat_mispredicts} !== 8'hEE) begin errors++; $display("FAIL stat_14: got %h want ee", {stat_lookups, stat_mispredicts}); end
      end
      if (i == 15) begin
        checks++; if ({stat_lookups, stat_mispredicts} !== 8'hFF) begin errors++; $display("FAIL stat_15: got %h want ff", {stat_lookups, stat_mispredicts}); end
      end
    end
    checks++; if ({stat_lookups, stat_mispredicts} !== 8'hFF) begin errors++; $display("FAIL stat_hold: got %h want ff", {stat_lookups, stat_mispredicts}); end
    RST = 1'b1;
    tick;
    RST = 1'b0;
    idle;
    checks++; if ({stat_lookups, stat_mispredicts} !== 8'h00) begin errors++; $display("FAIL stat_midrst: got %h want 00", {stat_lookups, stat_mispredicts}); end
  endtask
  initial begin
    RST = 1'b1;
    idle;
    rd_pc = '0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    tick;
    tick;
    RST = 1'b0;
    test_reset;
    test_mispredict;
    test_alloc;
    test_counter;
    test_no_bypass;
    test_alias;
    test_flush;
    test_stat_sat;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
